// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encoding, FSM states and iteration count for the muldiv_seq unit.
package muldiv_pkg;
  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;
  localparam int MULDIV_ITER = 32;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring-subtract (divide) iteration.
// Accumulator layout: multiply {partial_hi, multiplier_lo}; divide {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [63:0] acc_i,
  input  logic [31:0] b_i,
  input  op_e         op_i,
  output logic [63:0] acc_o
);
  logic        is_div;
  logic [32:0] sum;
  logic [32:0] rem;
  logic [32:0] diff;
  always_comb begin
    is_div = (op_i == OP_DIVU) || (op_i == OP_REMU);
    sum    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, b_i} : 33'd0);
    rem    = {acc_i[63:32], acc_i[31]};
    diff   = rem - {1'b0, b_i};
    acc_o  = !is_div ? {sum, acc_i[31:1]} :
             diff[32] ? {rem[31:0], acc_i[30:0], 1'b0} :
                        {diff[31:0], acc_i[30:0], 1'b1};
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 32-bit unsigned MUL/MULHU/DIVU/REMU unit with pipeline stall/flush handshake.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand and divide-by-zero cases after one BUSY cycle.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StartE,
  input  logic [1:0]  OpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        FlushE,
  output logic        StallE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] ResultE
);
  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d, acc_nxt;
  logic [31:0] b_q, b_d;
  op_e         op_q, op_d;
  logic [31:0] res_q, res_d;
  logic        early;
  logic [31:0] early_res;

  muldiv_step u_step (
    .acc_i (acc_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .acc_o (acc_nxt)
  );

`ifdef MULDIV_EARLY_OUT_EN
  // At cnt 0 the accumulator low word still holds the latched SrcAE.
  assign early     = (cnt_q == 6'd0) && ((b_q == 32'd0) || (!op_q[1] && acc_q[31:0] == 32'd0));
  assign early_res = !op_q[1] ? 32'd0 : op_q[0] ? acc_q[31:0] : 32'hFFFF_FFFF;
`else
  assign early     = 1'b0;
  assign early_res = 32'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (StartE && !FlushE) begin
          state_d = BUSY;
          cnt_d   = 6'd0;
          acc_d   = {32'd0, SrcAE};
          b_d     = SrcBE;
          op_d    = op_e'(OpE);
        end
      end
      BUSY: begin
        if (FlushE) begin
          state_d = IDLE;
        end else if (early) begin
          state_d = DONE;
          res_d   = early_res;
        end else if (cnt_q == 6'(MULDIV_ITER)) begin
          state_d = DONE;
          res_d   = op_q[0] ? acc_q[63:32] : acc_q[31:0];
        end else begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      b_q     <= 32'd0;
      op_q    <= OP_MUL;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  assign BusyE   = (state_q == BUSY);
  assign DoneE   = (state_q == DONE) && !FlushE;
  assign StallE  = rst_n && (((state_q == IDLE) && StartE && !FlushE) || (state_q == BUSY));
  assign ResultE = res_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven and scoreboard-checked bench for muldiv_seq, plus flush/restart/reset sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StartE = 1'b0;
  logic        FlushE = 1'b0;
  logic [1:0]  OpE = 2'b00;
  logic [31:0] SrcAE = 32'd0;
  logic [31:0] SrcBE = 32'd0;
  logic        StallE, BusyE, DoneE;
  logic [31:0] ResultE;

  int passed = 0;
  int total = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] last_res = 32'd0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .StartE  (StartE),
    .OpE     (OpE),
    .SrcAE   (SrcAE),
    .SrcBE   (SrcBE),
    .FlushE  (FlushE),
    .StallE  (StallE),
    .BusyE   (BusyE),
    .DoneE   (DoneE),
    .ResultE (ResultE)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 0 || (!op[1] && a == 0)) return 2;
`endif
    return 34;
  endfunction

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    @(negedge clk);
    OpE = op; SrcAE = a; SrcBE = b; StartE = 1'b1;
    #1 check("stall_on_start", StallE, 1);
    if (expect_done) begin
      exp_q.push_back(model(op, a, b));
      lat_q.push_back(exp_lat(op, a, b));
    end
    @(posedge clk);
    #1 StartE = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit chk_lat);
    int cyc = 0;
    bit stall_ok = 1'b1;
    logic [31:0] exp;
    int lat;
    forever begin
      @(negedge clk);
      if (DoneE) break;
      stall_ok &= StallE & BusyE;
      @(posedge clk);
      cyc++;
      if (cyc > 40) break;
    end
    if (!DoneE) begin
      check({name, "_timeout"}, 0, 1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      check({name, "_unexpected_done"}, 1, 0);
      return;
    end
    exp = exp_q.pop_front();
    lat = lat_q.pop_front();
    check({name, "_result"}, ResultE, exp);
    if (chk_lat) check({name, "_latency"}, cyc + 1, lat);
    check({name, "_stall_busy_cycles"}, stall_ok, 1);
    check({name, "_done_no_stall"}, {StallE, BusyE}, 0);
    @(negedge clk);
    check({name, "_done_pulse"}, DoneE, 0);
    check({name, "_result_hold"}, ResultE, exp);
    last_res = exp;
  endtask

  task automatic quiet_window(input string name);
    int dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (DoneE) dones++;
    end
    check({name, "_no_done"}, dones, 0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'h0000_1234, 32'h0000_5678, 32'h0626_0060};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[3]  = '{2'b10, 32'd100,       32'd7,         32'd14};
    vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2};
    vecs[5]  = '{2'b10, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5};
    vecs[7]  = '{2'b00, 32'd0,         32'd12345,     32'd0};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'd4,         32'd2};
    vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    vecs[10] = '{2'b11, 32'd7,         32'd100,       32'd7};
    vecs[11] = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'd1};

    #1;
    check("reset_busy", BusyE, 0);
    check("reset_done", DoneE, 0);
    check("reset_stall", StallE, 0);
    check("reset_result", ResultE, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      start(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      exp_q.push_back(vecs[i].res);
      lat_q.push_back(exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
      wait_done($sformatf("vec%0d", i), 1'b1);
    end

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      logic [1:0] op;
      a = $urandom; b = (i == 5) ? 32'd0 : $urandom_range(1, 32'hFFFF);
      op = 2'(i % 4);
      start(op, a, b, 1'b1);
      wait_done($sformatf("rand%0d", i), 1'b1);
    end

    start(2'b10, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk) FlushE = 1'b1;
    @(posedge clk);
    #1 FlushE = 1'b0;
    check("flush_idle", BusyE, 0);
    check("flush_result_kept", ResultE, last_res);
    quiet_window("flush");
    start(2'b10, 32'd1000, 32'd3, 1'b1);
    wait_done("after_flush", 1'b1);

    @(negedge clk);
    StartE = 1'b1; FlushE = 1'b1; OpE = 2'b00; SrcAE = 32'd9; SrcBE = 32'd9;
    #1 check("start_flush_stall", StallE, 0);
    @(posedge clk);
    #1 StartE = 1'b0; FlushE = 1'b0;
    check("start_flush_no_busy", BusyE, 0);

    start(2'b00, 32'h0000_1234, 32'h0000_5678, 1'b1);
    repeat (5) @(posedge clk);
    #1 StartE = 1'b1; OpE = 2'b10; SrcAE = 32'd77; SrcBE = 32'd5;
    @(posedge clk);
    #1 StartE = 1'b0;
    wait_done("restart_ignored", 1'b0);

    start(2'b01, 32'hFFFF_FFFF, 32'd3, 1'b0);
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", BusyE, 0);
    check("async_rst_done", DoneE, 0);
    check("async_rst_stall", StallE, 0);
    check("async_rst_result", ResultE, 0);
    @(negedge clk) rst_n = 1'b1;
    last_res = 32'd0;
    quiet_window("reset");
    check("post_reset_result", ResultE, 0);
    start(2'b11, 32'd100, 32'd7, 1'b1);
    wait_done("post_reset", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
